// File: rtl/fifo_enq_rr_arbiter_pkg.sv
// Shared types for the FIFO enqueue arbiter: payload word from the FIFO slice,
// requester id / burst counter widths and the arbiter state encoding.
package fifo_types;
    localparam int width_p = 32;
    typedef logic [width_p-1:0] word_t;
endpackage

package arb_types;
    import fifo_types::word_t;

    localparam int num_req_p   = 4;
    localparam int max_burst_p = 4;
    localparam int req_id_w_p  = $clog2(num_req_p);
    localparam int burst_w_p   = $clog2(max_burst_p + 1);

    typedef logic [req_id_w_p-1:0] req_id_t;
    typedef logic [burst_w_p-1:0]  burst_cnt_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Successor of a requester id in round-robin order (num_req_p need not be a power of two).
    function automatic req_id_t next_id(input req_id_t id);
        next_id = (id == req_id_t'(num_req_p - 1)) ? '0 : id + req_id_t'(1);
    endfunction
endpackage

// File: rtl/fifo_enq_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module fifo_enq_rr_arbiter_rr_pick
    import arb_types::*;
(
    input  logic [num_req_p-1:0] i_req,
    input  req_id_t              i_ptr,
    output req_id_t              o_pick,
    output logic                 o_any
);
    localparam logic [req_id_w_p:0] NUM_EXT = (req_id_w_p + 1)'(num_req_p);

    logic [2*num_req_p-1:0] w_dbl;
    logic [num_req_p-1:0]   w_rot;
    req_id_t                w_off;
    logic [req_id_w_p:0]    w_sum;

    // Rotating a doubled vector puts the pointer position at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: num_req_p];
    assign o_any = |i_req;

    always_comb begin
        w_off = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = req_id_t'(i);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= NUM_EXT) begin
            w_sum = w_sum - NUM_EXT;
        end
        o_pick = o_any ? w_sum[req_id_w_p-1:0] : '0;
    end
endmodule

// File: rtl/fifo_enq_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO enqueue port among num_req_p sources.
// Outputs toward the FIFO are independent of ready_i so no loop forms through the FIFO.
module fifo_enq_rr_arbiter
    import fifo_types::*;
    import arb_types::*;
(
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [num_req_p-1:0] req_valid_i,
    input  word_t                req_data_i [num_req_p],
    input  logic [num_req_p-1:0] req_last_i,
    output logic [num_req_p-1:0] req_ready_o,
    output logic                 valid_o,
    output word_t                data_o,
    input  logic                 ready_i,
    output req_id_t              grant_id_o,
    output logic                 locked_o
);
    arb_state_e r_state;
    req_id_t    r_rr_ptr;
    req_id_t    r_lock_id;
    burst_cnt_t r_beat_cnt;

    req_id_t    w_pick;
    logic       w_any;
    logic       w_locked;
    req_id_t    w_sel_id;
    logic       w_sel_valid;
    logic       w_accept;
    logic       w_release;

    fifo_enq_rr_arbiter_rr_pick u_rr_pick (
        .i_req  (req_valid_i),
        .i_ptr  (r_rr_ptr),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    assign w_locked    = (r_state == ARB_LOCKED);
    assign w_sel_id    = w_locked ? r_lock_id : w_pick;
    assign w_sel_valid = w_locked ? req_valid_i[r_lock_id] : w_any;
    assign w_accept    = w_sel_valid & ready_i;

    // A grant ends on the packet's last beat or once max_burst_p beats have gone through.
    assign w_release = req_last_i[w_sel_id] |
                       (w_locked ? (r_beat_cnt == burst_cnt_t'(max_burst_p - 1))
                                 : (max_burst_p == 1));

    assign valid_o    = w_sel_valid;
    assign data_o     = req_data_i[w_sel_id];
    assign grant_id_o = w_sel_id;
    assign locked_o   = w_locked;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            req_ready_o[i] = ready_i & w_sel_valid & (w_sel_id == req_id_t'(i));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_lock_id  <= '0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            if (w_release) begin
                r_state    <= ARB_IDLE;
                r_rr_ptr   <= next_id(w_sel_id);
                r_beat_cnt <= '0;
            end else if (!w_locked) begin
                r_state    <= ARB_LOCKED;
                r_lock_id  <= w_sel_id;
                r_beat_cnt <= burst_cnt_t'(1);
            end else begin
                r_beat_cnt <= r_beat_cnt + burst_cnt_t'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_enq_rr_arbiter.sv
// Bench for fifo_enq_rr_arbiter: per-requester beat queues feed the DUT, and a
// grant-level reference model predicts every cycle's selection and handshake.
module tb_fifo_enq_rr_arbiter;
    import fifo_types::*;
    import arb_types::*;

    localparam int NR = num_req_p;
    localparam int MB = max_burst_p;

    logic          clk_i;
    logic          reset_n_i;
    logic [NR-1:0] req_valid_i;
    word_t         req_data_i [NR];
    logic [NR-1:0] req_last_i;
    logic [NR-1:0] req_ready_o;
    logic          valid_o;
    word_t         data_o;
    logic          ready_i;
    req_id_t       grant_id_o;
    logic          locked_o;

    fifo_enq_rr_arbiter dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .ready_i     (ready_i),
        .grant_id_o  (grant_id_o),
        .locked_o    (locked_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int      checks = 0;
    int      errors = 0;
    word_t   q_d [NR][$];
    logic    q_l [NR][$];
    logic [NR-1:0] en;
    logic    rdy;
    int      seq;
    // Reference model: current owner (-1 = free), beats granted so far, rotation start.
    int      m_owner;
    int      m_cnt;
    int      m_ptr;
    word_t   acc_log [$];
    int      lock_cycles;
    int      g_obs;
    int      exp_gid;
    logic    exp_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            q_d[r].push_back(word_t'((r << 24) | seq));
            q_l[r].push_back(k == len - 1);
            seq++;
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NR; i++) n += q_d[i].size();
        return n;
    endfunction

    task automatic cycle();
        logic [NR-1:0] v;
        logic [NR-1:0] er;
        int            beats;
        logic          last;
        @(negedge clk_i);
        for (int i = 0; i < NR; i++) begin
            v[i]           = en[i] && (q_d[i].size() > 0);
            req_valid_i[i] = v[i];
            req_data_i[i]  = v[i] ? q_d[i][0] : '0;
            req_last_i[i]  = v[i] ? q_l[i][0] : 1'b0;
        end
        ready_i = rdy;
        if (m_owner < 0) begin
            exp_valid = 1'b0;
            exp_gid   = 0;
            for (int k = 0; k < NR; k++) begin
                if (!exp_valid && v[(m_ptr + k) % NR]) begin
                    exp_valid = 1'b1;
                    exp_gid   = (m_ptr + k) % NR;
                end
            end
        end else begin
            exp_gid   = m_owner;
            exp_valid = v[m_owner];
        end
        er = '0;
        if (exp_valid && rdy) er[exp_gid] = 1'b1;
        #1;
        g_obs = int'(grant_id_o);
        chk("valid_o", 64'(valid_o), 64'(exp_valid));
        chk("grant_id_o", 64'(grant_id_o), 64'(exp_gid));
        chk("req_ready_o", 64'(req_ready_o), 64'(er));
        chk("locked_o", 64'(locked_o), 64'(m_owner >= 0));
        if (exp_valid) chk("data_o", 64'(data_o), 64'(q_d[exp_gid][0]));
        if (locked_o) lock_cycles++;
        @(posedge clk_i);
        if (exp_valid && rdy) begin
            beats = (m_owner < 0) ? 1 : m_cnt + 1;
            last  = q_l[exp_gid][0];
            acc_log.push_back(q_d[exp_gid][0]);
            void'(q_d[exp_gid].pop_front());
            void'(q_l[exp_gid].pop_front());
            if (last || beats >= MB) begin
                m_owner = -1;
                m_cnt   = 0;
                m_ptr   = (exp_gid + 1) % NR;
            end else begin
                m_owner = exp_gid;
                m_cnt   = beats;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        en  = '1;
        rdy = 1'b1;
        while (pending() > 0 && n < 200) begin
            cycle();
            n++;
        end
        chk(tag, 64'(pending()), 64'd0);
    endtask

    initial begin
        word_t exp_seq [5];
        reset_n_i   = 1'b0;
        en          = '0;
        rdy         = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        ready_i     = 1'b1;
        for (int i = 0; i < NR; i++) req_data_i[i] = '0;
        seq         = 1;
        lock_cycles = 0;
        model_reset();

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_locked", 64'(locked_o), 64'd0);
        chk("rst_grant", 64'(grant_id_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // All four valid with single-beat packets: strict rotation.
        en = '1;
        for (int r = 0; r < NR; r++) begin
            push_pkt(r, 1);
            push_pkt(r, 1);
        end
        for (int k = 0; k < 2 * NR; k++) begin
            cycle();
            chk("rr_seq", 64'(g_obs), 64'(k % NR));
        end

        // Move rotation to req1, then a 3-beat packet on req1 competes with req0/req2.
        push_pkt(0, 1);
        cycle();
        acc_log.delete();
        lock_cycles = 0;
        push_pkt(1, 3);
        push_pkt(0, 1);
        push_pkt(2, 1);
        exp_seq[0] = q_d[1][0];
        exp_seq[1] = q_d[1][1];
        exp_seq[2] = q_d[1][2];
        exp_seq[3] = q_d[2][0];
        exp_seq[4] = q_d[0][0];
        repeat (5) cycle();
        for (int k = 0; k < 5; k++) chk("pkt3_order", 64'(acc_log[k]), 64'(exp_seq[k]));
        chk("pkt3_locked_cycles", 64'(lock_cycles), 64'd2);

        // Six-beat packet on req2 with others pending: forced release after MB beats.
        push_pkt(2, 6);
        push_pkt(3, 1);
        push_pkt(0, 1);
        push_pkt(1, 1);
        drain("burst_drain");

        // Back-pressure while locked mid-packet.
        push_pkt(3, 4);
        cycle();
        cycle();
        rdy = 1'b0;
        push_pkt(0, 1);
        repeat (5) cycle();
        rdy = 1'b1;
        drain("stall_drain");

        // Locked requester drops valid for three cycles.
        push_pkt(0, 4);
        cycle();
        push_pkt(1, 1);
        push_pkt(2, 1);
        en[0] = 1'b0;
        repeat (3) cycle();
        en[0] = 1'b1;
        drain("bubble_drain");

        // Asynchronous reset while locked on req3 after two beats.
        push_pkt(3, 4);
        cycle();
        cycle();
        chk("pre_rst_locked", 64'(locked_o), 64'd1);
        @(negedge clk_i);
        en          = '0;
        req_valid_i = '0;
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("arst_locked", 64'(locked_o), 64'd0);
        chk("arst_grant", 64'(grant_id_o), 64'd0);
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_ready", 64'(req_ready_o), 64'd0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        push_pkt(1, 1);
        en = '1;
        cycle();
        chk("post_rst_grant", 64'(g_obs), 64'd1);
        drain("rst_drain");

        // Randomized traffic, valid gaps and back-pressure.
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (q_d[r].size() == 0 && $urandom_range(0, 2) == 0)
                    push_pkt(r, int'($urandom_range(1, 7)));
            end
            en  = NR'($urandom) | NR'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
